// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding and parity modes.
// Kept in a package so a matching receiver can use the same encodings.
package uart_tx_buffered_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic {
        PARITY_EVEN = 1'b0,
        PARITY_ODD  = 1'b1
    } parity_mode_e;

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Single-clock FIFO with occupancy count, full/empty flags and a drop-on-full overflow strobe.
// Read data is the current head word; a pushed word becomes visible the cycle after the push.
module uart_tx_buffered_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              push;
    logic              pop;

    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign push     = wr_en && !full;
    assign pop      = rd_en && !empty;
    // A write that meets a full FIFO is lost even if a pop frees a slot this cycle.
    assign overflow = wr_en && full;
    assign rd_data  = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter fed from an internal TX FIFO; frames are sent back-to-back with one idle clock.
// Frame format and bit period are captured when a word is popped and held for the whole frame.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int BAUD_W     = 20
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic [BAUD_W-1:0]             baud_value,
    input  logic                          bit8,
    input  logic                          parity_en,
    input  logic                          odd_n_even,
    input  logic                          two_stop,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    tx_state_e          state_reg;
    tx_state_e          state_next;
    logic [BAUD_W-1:0]  baud_cnt_reg;
    logic [BAUD_W-1:0]  baud_lat_reg;
    logic [CNT_W-1:0]   bit_cnt_reg;
    logic [DATA_W-1:0]  shift_reg;
    logic               bit8_reg;
    logic               parity_en_reg;
    logic               two_stop_reg;
    logic               parity_bit_reg;

    logic               fifo_rd_en;
    logic [DATA_W-1:0]  fifo_data;
    logic [DATA_W-1:0]  load_bits;
    logic               load_parity;
    logic               bit_tick;
    logic [CNT_W-1:0]   nbits;
    logic               last_data;
    logic               last_stop;

    uart_tx_buffered_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (fifo_rd_en),
        .rd_data  (fifo_data),
        .full     (full),
        .empty    (empty),
        .count    (fifo_count),
        .overflow (overflow)
    );

    // Parity covers only the bits actually sent, so the MSB is masked when bit8 is low.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_load
            if (gi == DATA_W - 1) begin : g_msb
                assign load_bits[gi] = fifo_data[gi] & bit8;
            end else begin : g_low
                assign load_bits[gi] = fifo_data[gi];
            end
        end
    endgenerate

    assign load_parity = (^load_bits) ^ (parity_mode_e'(odd_n_even) == PARITY_ODD);
    assign bit_tick    = (state_reg != ST_IDLE) && (baud_cnt_reg == baud_lat_reg);
    assign nbits       = bit8_reg ? CNT_W'(DATA_W) : CNT_W'(DATA_W - 1);
    assign last_data   = (bit_cnt_reg == nbits - CNT_W'(1));
    assign last_stop   = (bit_cnt_reg == (two_stop_reg ? CNT_W'(1) : CNT_W'(0)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (!empty) state_next = ST_START;
            ST_START:  if (bit_tick) state_next = ST_DATA;
            ST_DATA:   if (bit_tick && last_data) state_next = parity_en_reg ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_tick) state_next = ST_STOP;
            ST_STOP:   if (bit_tick && last_stop) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx         = 1'b1;
        tx_busy    = (state_reg != ST_IDLE);
        tx_done    = 1'b0;
        fifo_rd_en = 1'b0;
        case (state_reg)
            ST_IDLE:   fifo_rd_en = !empty;
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = shift_reg[0];
            ST_PARITY: tx = parity_bit_reg;
            ST_STOP:   tx_done = bit_tick && last_stop;
            default:   tx = 1'b1;
        endcase
    end

    // Bit counter restarts on every state change, so it indexes data bits and then stop bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt_reg   <= '0;
            baud_lat_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            bit8_reg       <= 1'b0;
            parity_en_reg  <= 1'b0;
            two_stop_reg   <= 1'b0;
            parity_bit_reg <= 1'b0;
        end else if (fifo_rd_en) begin
            baud_cnt_reg   <= '0;
            baud_lat_reg   <= baud_value;
            bit_cnt_reg    <= '0;
            shift_reg      <= fifo_data;
            bit8_reg       <= bit8;
            parity_en_reg  <= parity_en;
            two_stop_reg   <= two_stop;
            parity_bit_reg <= load_parity;
        end else if (state_reg != ST_IDLE) begin
            baud_cnt_reg <= bit_tick ? '0 : baud_cnt_reg + BAUD_W'(1);
            if (bit_tick) begin
                if (state_reg == ST_DATA) begin
                    shift_reg <= shift_reg >> 1;
                end
                bit_cnt_reg <= (state_next != state_reg) ? '0 : bit_cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomised scoreboard bench for uart_tx_buffered: a timing-level model predicts pops and frames,
// a monitor checks FIFO status every cycle and the serial waveform of every frame.
module tb_uart_tx_buffered;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int BAUD_W     = 20;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [7:0]        wr_data = '0;
    logic [BAUD_W-1:0] baud_value = '0;
    logic              bit8 = 1'b0;
    logic              parity_en = 1'b0;
    logic              odd_n_even = 1'b0;
    logic              two_stop = 1'b0;
    logic              tx, tx_busy, tx_done, full, empty, overflow;
    logic [4:0]        fifo_count;

    uart_tx_buffered #(
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .BAUD_W(BAUD_W)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .baud_value(baud_value), .bit8(bit8), .parity_en(parity_en),
        .odd_n_even(odd_n_even), .two_stop(two_stop), .tx(tx), .tx_busy(tx_busy),
        .tx_done(tx_done), .full(full), .empty(empty), .fifo_count(fifo_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] word;
        bit         b8, pen, odd, two;
        int         baud;
        int         start_cyc;
    } frame_t;

    typedef struct {
        int count;
        bit ovf;
    } status_t;

    frame_t     frame_q[$];
    status_t    status_q[$];
    logic [7:0] mdl_fifo[$];
    int         free_at = 0;
    int         last_pop_cyc = 0;

    function automatic int frame_len(bit b8, bit pen, bit two, int baud);
        return (1 + (b8 ? 8 : 7) + int'(pen) + 1 + int'(two)) * (baud + 1);
    endfunction

    // One clock of stimulus; the model decides drops and pops from occupancy and transmitter timing.
    task automatic step(input bit wr, input logic [7:0] d);
        int     cnt_before;
        bit     ovf;
        frame_t f;
        wr_en   = wr;
        wr_data = d;
        cnt_before = mdl_fifo.size();
        ovf = wr && (cnt_before == FIFO_DEPTH);
        status_q.push_back('{cnt_before, ovf});
        if (cyc >= free_at && cnt_before > 0) begin
            f.word      = mdl_fifo.pop_front();
            f.b8        = bit8;
            f.pen       = parity_en;
            f.odd       = odd_n_even;
            f.two       = two_stop;
            f.baud      = int'(baud_value);
            f.start_cyc = cyc + 1;
            frame_q.push_back(f);
            last_pop_cyc = cyc;
            free_at = cyc + frame_len(f.b8, f.pen, f.two, f.baud) + 1;
        end
        if (wr && !ovf) mdl_fifo.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int baud, input bit b8, input bit pen, input bit odd, input bit two);
        baud_value = BAUD_W'(baud);
        bit8       = b8;
        parity_en  = pen;
        odd_n_even = odd;
        two_stop   = two;
    endtask

    task automatic drain();
        int guard = 0;
        while ((mdl_fifo.size() > 0 || cyc < free_at + 2) && guard < 3000) begin
            step(1'b0, 8'h00);
            guard++;
        end
        tests++;
        if (frame_q.size() != 0 || in_frame) begin
            fails++;
            $display("FAIL drain: %0d frames still pending (in_frame=%0d), required 0", frame_q.size(), in_frame);
            frame_q.delete();
        end
    endtask

    // Monitor state
    bit     in_frame = 1'b0;
    frame_t cur;
    bit     exp_bits[$];
    int     off, flen;
    bit     ferr;
    string  ferr_msg;

    always @(negedge clk) begin : monitor
        status_t s;
        bit      exp_tx, exp_done, par;
        int      nb;
        if (!reset) begin
            tests++;
            if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || empty !== 1'b1 ||
                full !== 1'b0 || fifo_count !== 5'd0 || overflow !== 1'b0) begin
                fails++;
                $display("FAIL reset_state: tx=%b busy=%b done=%b empty=%b full=%b count=%0d ovf=%b, required 1 0 0 1 0 0 0",
                         tx, tx_busy, tx_done, empty, full, fifo_count, overflow);
            end
            in_frame = 1'b0;
            status_q.delete();
        end else begin
            if (status_q.size() > 0) begin
                s = status_q.pop_front();
                tests++;
                if (fifo_count !== 5'(s.count) || full !== (s.count == FIFO_DEPTH) ||
                    empty !== (s.count == 0) || overflow !== s.ovf) begin
                    fails++;
                    $display("FAIL status cyc=%0d: count=%0d full=%b empty=%b overflow=%b, required count=%0d full=%b empty=%b overflow=%b",
                             cyc, fifo_count, full, empty, overflow, s.count,
                             s.count == FIFO_DEPTH, s.count == 0, s.ovf);
                end
            end
            if (!in_frame && frame_q.size() > 0 && frame_q[0].start_cyc == cyc) begin
                cur = frame_q.pop_front();
                tests++;
                if (tx !== 1'b0) begin
                    fails++;
                    $display("FAIL frame_start cyc=%0d word=%02h: tx=%b, required start bit 0", cyc, cur.word, tx);
                end else begin
                    exp_bits.delete();
                    exp_bits.push_back(1'b0);
                    nb  = cur.b8 ? 8 : 7;
                    par = cur.odd;
                    for (int i = 0; i < nb; i++) begin
                        exp_bits.push_back(cur.word[i]);
                        par ^= cur.word[i];
                    end
                    if (cur.pen) exp_bits.push_back(par);
                    exp_bits.push_back(1'b1);
                    if (cur.two) exp_bits.push_back(1'b1);
                    flen     = exp_bits.size() * (cur.baud + 1);
                    off      = 0;
                    ferr     = 1'b0;
                    in_frame = 1'b1;
                end
            end else if (!in_frame) begin
                tests++;
                if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
                    fails++;
                    $display("FAIL idle_line cyc=%0d: tx=%b busy=%b done=%b, required 1 0 0", cyc, tx, tx_busy, tx_done);
                end
            end
            if (in_frame) begin
                exp_tx   = exp_bits[off / (cur.baud + 1)];
                exp_done = (off == flen - 1);
                if (!ferr && (tx !== exp_tx || tx_busy !== 1'b1 || tx_done !== exp_done)) begin
                    ferr = 1'b1;
                    ferr_msg = $sformatf("offset %0d tx=%b busy=%b done=%b, required tx=%b busy=1 done=%b",
                                         off, tx, tx_busy, tx_done, exp_tx, exp_done);
                end
                off++;
                if (off == flen) begin
                    tests++;
                    in_frame = 1'b0;
                    if (ferr) begin
                        fails++;
                        $display("FAIL frame word=%02h b8=%0d par=%0d odd=%0d two=%0d baud=%0d: %s",
                                 cur.word, cur.b8, cur.pen, cur.odd, cur.two, cur.baud, ferr_msg);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int target;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        free_at = cyc;

        // 7 data bits, even parity, 4 clocks per bit
        set_cfg(3, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h6A);
        drain();

        // 8 data bits, odd parity, two stop bits, 2 clocks per bit
        set_cfg(1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 8'hFF);
        drain();

        // Burst of 18 writes at one clock per bit
        set_cfg(0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++) step(1'b1, 8'(i));
        drain();

        // Burst at a slow rate so the FIFO fills and drops words
        set_cfg(3, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h80 + i));
        drain();

        // Config changes mid-frame apply only to the next popped word
        set_cfg(2, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h3C);
        step(1'b1, 8'hC3);
        repeat (5) step(1'b0, 8'h00);
        set_cfg(1, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();

        // Push and pop in the same cycle with five words queued
        set_cfg(3, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h40 + i));
        for (int g = 0; g < 200 && cyc < free_at; g++) step(1'b0, 8'h00);
        step(1'b1, 8'h77);
        drain();

        // Randomised traffic with occasional config changes
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(0, 19) == 0)
                    set_cfg($urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                step(($urandom_range(0, 99) < ((blk % 2 == 0) ? 8 : 60)), 8'($urandom));
            end
        end
        drain();

        // Reset asserted during data bit 3 of a frame with more words queued
        set_cfg(3, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA5);
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        target = last_pop_cyc + 18;
        for (int g = 0; g < 100 && cyc < target; g++) step(1'b0, 8'h00);
        wr_en = 1'b0;
        #2 reset = 1'b0;
        mdl_fifo.delete();
        frame_q.delete();
        status_q.delete();
        #1;
        tests++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || empty !== 1'b1 || fifo_count !== 5'd0) begin
            fails++;
            $display("FAIL reset_midframe: tx=%b busy=%b done=%b empty=%b count=%0d, required 1 0 0 1 0",
                     tx, tx_busy, tx_done, empty, fifo_count);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        free_at = cyc;
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00);
        set_cfg(0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h5A);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
